// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the two-requester AES request scheduler.
package aes_sched_pkg;

  localparam int BLOCK_W         = 128;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the preferred requester and
// flips to the other one after every accepted grant.
module aes_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic gnt0,
  output logic gnt1
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt0  = req0 & (~req1 | ~ptr_q);
    gnt1  = req1 & (~req0 | ptr_q);
    ptr_d = ptr_q;
    // After granting 0 prefer 1 next time, and vice versa.
    if (advance && (gnt0 || gnt1)) ptr_d = gnt0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/aes_req_scheduler.sv
// Shares one AES core between two requesters (IDLE/RUN/RESP/GAP).
// Optional RUN watchdog enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_req_scheduler
  import aes_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic               AES_clk,
  input  logic               AES_rst_n,
  input  logic               req0_valid,
  input  logic               req1_valid,
  output logic               req0_ready,
  output logic               req1_ready,
  input  logic [BLOCK_W-1:0] req0_data,
  input  logic [BLOCK_W-1:0] req1_data,
  input  logic [BLOCK_W-1:0] req0_key,
  input  logic [BLOCK_W-1:0] req1_key,
  output logic               core_en,
  output logic [BLOCK_W-1:0] core_data_in,
  output logic [BLOCK_W-1:0] core_key_in,
  input  logic [BLOCK_W-1:0] core_data_out,
  input  logic               core_data_out_valid,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BLOCK_W-1:0] rsp_data,
  output logic               rsp_id,
  output logic               rsp_err
);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic               id_q, id_d;
  logic [BLOCK_W-1:0] rsp_data_q, rsp_data_d;
  logic               gnt0, gnt1;
  logic               grant_ok;
  logic               timeout_hit;

  // Reset gates the strobes so a held request is never acknowledged in reset.
  assign grant_ok = (state_q == ST_IDLE) && AES_rst_n;

  aes_rr_arb2 u_arb (
    .clk     (AES_clk),
    .rst_n   (AES_rst_n),
    .req0    (req0_valid),
    .req1    (req1_valid),
    .advance (grant_ok),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign req0_ready   = grant_ok & gnt0;
  assign req1_ready   = grant_ok & gnt1;
  assign core_en      = (state_q == ST_RUN);
  assign core_data_in = core_en ? data_q : '0;
  assign core_key_in  = core_en ? key_q  : '0;
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_data     = rsp_data_q;
  assign rsp_id       = id_q;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    key_d      = key_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          data_d  = gnt1 ? req1_data : req0_data;
          key_d   = gnt1 ? req1_key  : req0_key;
          id_d    = gnt1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A real result beats a simultaneous watchdog expiry.
        if (core_data_out_valid) begin
          rsp_data_d = core_data_out;
          state_d    = ST_RESP;
        end else if (timeout_hit) begin
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready) state_d = ST_GAP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      key_q      <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      key_q      <= key_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef AES_SCHED_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       rsp_err_q, rsp_err_d;

  always_comb begin
    cnt_d       = (state_q == ST_RUN) ? cnt_q + 8'd1 : 8'd0;
    timeout_hit = (state_q == ST_RUN) && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    rsp_err_d   = rsp_err_q;
    if (state_q == ST_RUN) begin
      if (core_data_out_valid) rsp_err_d = 1'b0;
      else if (timeout_hit)    rsp_err_d = 1'b1;
    end
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      cnt_q     <= 8'd0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  logic [7:0] timeout_unused;

  assign timeout_unused = 8'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Directed bench for aes_req_scheduler with a behavioural stub AES core.
// Timeout vectors are included when AES_SCHED_TIMEOUT_EN is defined.
module tb_aes_req_scheduler;

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 64;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [127:0] req0_data, req1_data, req0_key, req1_key;
  logic         core_en;
  logic [127:0] core_data_in, core_key_in, core_data_out;
  logic         core_data_out_valid;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [127:0] rsp_data;

  logic         stub_vld = 1'b0;
  logic [127:0] stub_data = '0;
  int           en_cnt = 0;
  int           stub_lat = 1;
  logic         spur_vld;
  logic [127:0] spur_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit           v0, v1;
    logic [127:0] d0, k0, d1, k1;
    int           lat, stall;
    bit           exp_id, exp_err;
    logic [127:0] exp_data;
    int           exp_len;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  aes_req_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .AES_clk             (clk),
    .AES_rst_n           (rst_n),
    .req0_valid          (req0_valid),
    .req1_valid          (req1_valid),
    .req0_ready          (req0_ready),
    .req1_ready          (req1_ready),
    .req0_data           (req0_data),
    .req1_data           (req1_data),
    .req0_key            (req0_key),
    .req1_key            (req1_key),
    .core_en             (core_en),
    .core_data_in        (core_data_in),
    .core_key_in         (core_key_in),
    .core_data_out       (core_data_out),
    .core_data_out_valid (core_data_out_valid),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .rsp_id              (rsp_id),
    .rsp_err             (rsp_err)
  );

  function automatic logic [127:0] stub_f(input logic [127:0] d, input logic [127:0] k);
    return d ^ {k[63:0], k[127:64]};
  endfunction

  // Stub core: result valid for one cycle after stub_lat enabled cycles.
  always @(posedge clk) begin
    en_cnt    <= core_en ? en_cnt + 1 : 0;
    stub_vld  <= core_en && (en_cnt == stub_lat - 1);
    stub_data <= stub_f(core_data_in, core_key_in);
  end

  assign core_data_out       = spur_vld ? spur_data : stub_data;
  assign core_data_out_valid = stub_vld | spur_vld;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input bit v0, input bit v1, input logic [127:0] d0,
                              input logic [127:0] k0, input logic [127:0] d1,
                              input logic [127:0] k1, input int lat, input int stall,
                              input bit exp_id, input bit exp_err, input int exp_len);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.d0 = d0; v.k0 = k0; v.d1 = d1; v.k1 = k1;
    v.lat = lat; v.stall = stall; v.exp_id = exp_id; v.exp_err = exp_err;
    v.exp_len = exp_len;
    v.exp_data = exp_err ? 128'h0 : (exp_id ? stub_f(d1, k1) : stub_f(d0, k0));
    return v;
  endfunction

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE.
  task automatic run_txn(input vec_t v);
    int cyc, run_len;
    bit bad;
    logic [127:0] ed, ek, rd;
    ed = v.exp_id ? v.d1 : v.d0;
    ek = v.exp_id ? v.k1 : v.k0;
    stub_lat = v.lat;
    req0_valid = v.v0; req0_data = v.d0; req0_key = v.k0;
    req1_valid = v.v1; req1_data = v.d1; req1_key = v.k1;
    #1;
    cyc = 0;
    while (!(req0_ready || req1_ready) && cyc < 20) begin
      @(posedge clk); #2; cyc++;
    end
    chk("grant_seen", 128'(cyc < 20), 128'd1);
    chk("grant_id", 128'(req1_ready), 128'(v.exp_id));
    chk("grant_onehot", 128'(req0_ready & req1_ready), 128'd0);
    @(posedge clk); #1;
    if (v.exp_id) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    chk("ready_pulse", {req0_ready, req1_ready}, 128'd0);
    chk("run_en", 128'(core_en), 128'd1);
    chk("run_data", core_data_in, ed);
    chk("run_key", core_key_in, ek);
    run_len = 1; bad = 0; cyc = 0;
    while (!rsp_valid && cyc < 300) begin
      @(posedge clk); #2; cyc++;
      if (!rsp_valid) begin
        run_len++;
        if (core_en !== 1'b1 || core_data_in !== ed || core_key_in !== ek ||
            req0_ready || req1_ready) bad = 1;
      end
    end
    chk("rsp_seen", 128'(cyc < 300), 128'd1);
    chk("run_len", 128'(run_len), 128'(v.exp_len));
    chk("run_hold", 128'(bad), 128'd0);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_id", 128'(rsp_id), 128'(v.exp_id));
    chk("rsp_err", 128'(rsp_err), 128'(v.exp_err));
    chk("resp_en", 128'(core_en), 128'd0);
    chk("resp_din_zero", core_data_in | core_key_in, 128'd0);
    rd = rsp_data;
    bad = 0;
    for (int i = 0; i < v.stall; i++) begin
      @(posedge clk); #1;
      spur_vld  = (i == 2);
      spur_data = ~rd;
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== rd || rsp_err !== v.exp_err ||
          core_en !== 1'b0 || req0_ready || req1_ready) bad = 1;
    end
    spur_vld = 1'b0;
    if (v.stall > 0) chk("stall_hold", 128'(bad), 128'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    #1;
    chk("gap_state", {rsp_valid, core_en, req0_ready, req1_ready}, 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0; spur_vld = 1'b0; spur_data = '0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = {4{32'hdeadbeef}}; req0_key = {4{32'h12345678}};
    req1_data = {4{32'hcafef00d}}; req1_key = {4{32'h0badc0de}};
    #3;
    chk("rst_ready", {req0_ready, req1_ready}, 128'd0);
    chk("rst_ctrl", {core_en, rsp_valid, rsp_err, rsp_id}, 128'd0);
    chk("rst_rsp_data", rsp_data, 128'd0);
    chk("rst_core_in", core_data_in | core_key_in, 128'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl.push_back(mk(1, 1, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                     128'hffeeddccbbaa99887766554433221100, 128'h0f0e0d0c0b0a09080706050403020100,
                     3, 0, 0, 0, 4));
    tbl.push_back(mk(1, 1, 128'h1, 128'h2, 128'habcdef0123456789abcdef0123456789, 128'h5555aaaa5555aaaa,
                     1, 10, 1, 0, 2));
    tbl.push_back(mk(1, 0, 128'h3, {4{32'h80000001}}, 128'h0, 128'h0, 5, 0, 0, 0, 6));
    tbl.push_back(mk(0, 1, 128'h0, 128'h0, {16{8'h5a}}, {16{8'ha5}}, 2, 0, 1, 0, 3));
    tbl.push_back(mk(0, 1, 128'h0, 128'h0, {8{16'h1234}}, {2{64'h1}}, 1, 0, 1, 0, 2));
    tbl.push_back(mk(1, 1, {4{32'h01020304}}, 128'h7, 128'h9, 128'h8, 4, 6, 0, 0, 5));
    tbl.push_back(mk(0, 1, 128'h0, 128'h0, 128'h9, 128'h8, 2, 0, 1, 0, 3));
    tbl.push_back(mk(1, 0, {2{64'hfedcba9876543210}}, 128'h11, 128'h0, 128'h0, 2, 0, 0, 0, 3));
    foreach (tbl[i]) run_txn(tbl[i]);

    // Pointer now favours requester 1; abort its operation with reset mid-RUN.
    stub_lat = 50;
    req0_valid = 1'b1; req0_data = 128'h77; req0_key = 128'h66;
    req1_valid = 1'b1; req1_data = 128'h55; req1_key = 128'h44;
    #1;
    chk("abort_grant", {req0_ready, req1_ready}, 128'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {core_en, rsp_valid, rsp_err, rsp_id, req0_ready, req1_ready}, 128'd0);
    chk("abort_core_in", core_data_in | core_key_in, 128'd0);
    chk("abort_rsp_data", rsp_data, 128'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(mk(1, 1, 128'h77, 128'h66, 128'h55, 128'h44, 2, 0, 0, 0, 3));
`ifdef AES_SCHED_TIMEOUT_EN
    run_txn(mk(0, 1, 128'h0, 128'h0, 128'h55, 128'h44, 1000, 4, 1, 1, 16));
    run_txn(mk(1, 0, 128'h1234, 128'h4321, 128'h0, 128'h0, 15, 0, 0, 0, 16));
`else
    run_txn(mk(0, 1, 128'h0, 128'h0, 128'h55, 128'h44, 80, 0, 1, 0, 81));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_req_scheduler.md
AES_REQ_SCHEDULER -- requirements
Module: aes_req_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, shall set the maximum RUN-state cycles before abort (only used when AES_SCHED_TIMEOUT_EN is defined).
REQ-002 AES_clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-003 AES_rst_n  input  1  shall be the reset, asynchronous and active-low.
REQ-004 req0_valid / req1_valid  input  1 each  shall signal a pending encryption request from requester 0 / 1.
REQ-005 req0_ready / req1_ready  output  1 each  shall be the one-cycle accept strobes to requester 0 / 1.
REQ-006 req0_data, req1_data, req0_key, req1_key  input  128 each  shall be the plaintext and key, sampled on acceptance.
REQ-007 core_en  output  1  shall drive AES_en of the shared AES_top core.
REQ-008 core_data_in, core_key_in  output  128 each  shall drive AES_data_in and AES_key_in of the core.
REQ-009 core_data_out  input  128, core_data_out_valid  input  1  shall be the core result and its valid strobe.
REQ-010 rsp_valid  output  1, rsp_ready  input  1, rsp_data  output  128, rsp_id  output  1, rsp_err  output  1  shall form the single response channel.

Function
REQ-011 FSM states shall be IDLE, RUN, RESP and GAP.
REQ-012 IDLE: with any reqN_valid high, the scheduler shall grant one requester, pulse its reqN_ready for exactly that cycle, latch its data/key and id, and enter RUN next cycle.
REQ-013 Arbitration shall be round-robin: a pointer (reset 0) selects the preferred requester, and after each grant it points to the other requester.
REQ-014 Simultaneous requests shall be granted to the pointer's requester; a single request shall be granted regardless of the pointer.
REQ-015 RUN: core_en shall be 1 and core_data_in/core_key_in shall hold the latched values unchanged for the whole state.
REQ-016 RUN: on core_data_out_valid=1, the scheduler shall capture core_data_out into rsp_data, clear rsp_err, and enter RESP with core_en=0 from the next cycle.
REQ-017 RESP: rsp_valid shall be 1 with stable rsp_data/rsp_id/rsp_err until the cycle rsp_ready=1, then go to GAP.
REQ-018 GAP: one cycle with core_en=0 and no grant, then IDLE, guaranteeing an en low gap between operations.
REQ-019 core_data_out_valid outside RUN shall be ignored.
REQ-020 No reqN_ready shall be asserted outside IDLE; requesters hold reqN_valid until accepted.
REQ-021 core_data_in/core_key_in shall be 0 in IDLE, RESP and GAP.

Reset
REQ-022 While AES_rst_n=0: state IDLE, pointer 0, core_en 0, reqN_ready 0, rsp_valid 0, rsp_err 0, rsp_id 0, and all 128-bit outputs and latches 0.
REQ-023 Reset asserted mid-RUN or mid-RESP shall abort immediately with no response delivered; the in-flight request is lost.

Configuration
REQ-024 With AES_SCHED_TIMEOUT_EN defined, an 8-bit RUN cycle counter (cleared on RUN entry) reaching TIMEOUT_CYCLES shall force RESP with rsp_err=1, rsp_data=0, core_en=0.
REQ-025 If core_data_out_valid and timeout occur in the same cycle, the valid result shall win (rsp_err=0).
REQ-026 Without AES_SCHED_TIMEOUT_EN, no counter shall exist, rsp_err shall be tied 0 and RUN shall wait indefinitely.

Structure
REQ-027 A shared package aes_sched_pkg shall hold the state enum (IDLE, RUN, RESP, GAP), the 128-bit block width constant and the TIMEOUT_CYCLES default.
REQ-028 A single sub-module aes_rr_arb2 shall implement the 2-way round-robin grant and pointer; FSM and datapath latches stay in aes_req_scheduler.

Verification
REQ-029 Req0 key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, real AES_top -> rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id 0, rsp_err 0.
REQ-030 Both requesters valid at t0, after reset -> grants 0 then 1; second request 1 again with 0 valid -> grant 1 (pointer back to 0 afterwards).
REQ-031 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid and rsp_data stable, core_en 0, no reqN_ready pulses.
REQ-032 Stub core never asserts valid, macro defined, TIMEOUT_CYCLES=16 -> rsp_valid after 16 RUN cycles with rsp_err 1, rsp_data 0.
REQ-033 AES_rst_n pulled low 5 cycles into RUN -> core_en 0 and all outputs 0 asynchronously; after release the next request is served by requester 0's pointer.
REQ-034 Back-to-back requests -> core_en shows at least one low cycle (GAP) between consecutive RUN periods.
